mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage that sits between the EX/MEM pipeline register and the MEM/WB register.
- Accepts one load/store per handshake and performs byte/half/word alignment and sign/zero extension.
- Drives a request/ready data-RAM port, holds back the upstream stages until the access finishes, and delivers aligned load data plus writeback control to MEM/WB.
- Non-memory ops pass through with one-cycle latency.

Parameters:
- DATA_W, 32, data and address width.
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT, 255, maximum cycles waiting for ramReady before a bus error is reported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inValid  in  1  EX/MEM holds a valid instruction.
- memRead  in  1  instruction is a load.
- memWrite  in  1  instruction is a store.
- funct3  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- addr  in  DATA_W  effective address; also the ALU result.
- storeData  in  DATA_W  rs2 value for stores.
- regWriteEnableIn  in  1  writeback enable from EX.
- writeBackAddrIn  in  REG_ADDR_W  destination register.
- stall  out  1  freeze EX/MEM and earlier stages.
- ramReq  out  1  RAM request.
- ramWe  out  1  RAM write.
- ramAddr  out  DATA_W  word-aligned address (addr[1:0] forced to 00).
- ramWdata  out  DATA_W  store data replicated into lanes.
- ramBe  out  4  byte enables.
- ramReady  in  1  RAM completes the request in this cycle.
- ramRdata  in  DATA_W  read word, valid when ramReady=1.
- outValid  out  1  result valid to MEM/WB.
- select  out  1  1 means MEM/WB takes loadData; 0 means it takes aluData.
- loadData  out  DATA_W  aligned and extended load value.
- aluData  out  DATA_W  registered addr/ALU result.
- regWriteEnableOut  out  1  writeback enable.
- writeBackAddrOut  out  REG_ADDR_W  destination register.
- misalignErr  out  1  one-cycle pulse: misaligned access.
- busErr  out  1  one-cycle pulse: RAM timeout.

Behaviour:
- Reset (async, rst_n=0): every output is 0, FSM goes to IDLE, timeout counter is 0. An access in flight is abandoned: ramReq drops immediately and no result is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, inValid=1 with neither memRead nor memWrite:
  - Register aluData, regWriteEnable and writeBackAddr.
  - Next cycle: outValid=1, select=0.
  - stall=0; latency 1.
- IDLE, inValid=1 with memRead or memWrite:
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=00.
  - Misaligned: no RAM request. Next cycle: misalignErr=1, outValid=1, regWriteEnableOut=0. stall=0.
  - Aligned: capture the operation, go to ACCESS, stall=1 combinationally in this cycle.
  - memRead=memWrite=1: treated as a load.
- ACCESS:
  - Outputs: ramReq=1 and ramWe=store. ramAddr, ramWdata and ramBe stay stable until ramReady.
  - Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Write data: byte lane data is storeData[7:0] replicated ×4; half lane data is storeData[15:0] replicated ×2.
  - stall=1 throughout.
  - The counter increments each cycle without ramReady. Reaching TIMEOUT: drop ramReq, pulse busErr, emit a result with regWriteEnableOut=0, go to IDLE.
  - On ramReady: the load value is shifted right by addr[1:0]*8 and extended per funct3, then registered into loadData. Go to RESP.
- RESP:
  - outValid=1 for one cycle.
  - select=1 for loads. Stores: select=0, regWriteEnableOut=0.
  - stall=0 in this cycle, so upstream may present the next instruction, which IDLE logic handles in the same cycle (back-to-back accesses).
- outValid is 0 in every cycle without a result. On those cycles the other result outputs hold their last value.
- ramReady in IDLE or RESP is ignored.
- inValid is ignored while stall=1; upstream holds its inputs.
- Minimum load/store latency is 2 cycles from acceptance to outValid, with ramReady in the first ACCESS cycle.

Test Plan:
- ALU pass-through: inValid=1, memRead=memWrite=0, addr=0x1234, rd=5, wen=1 -> next cycle outValid=1, select=0, aluData=0x1234, writeBackAddrOut=5, stall never 1.
- LB sign: addr=0x103, funct3=000, ramRdata=0x80FF_0000 with ramReady after 3 cycles -> ramAddr=0x100, ramBe=0000 during wait?
  - Correction: ramBe=1000. stall=1 for 4 cycles, then loadData=0xFFFF_FF80, select=1.
- LHU/LW: addr=0x202, funct3=101, ramRdata=0xBEEF_1234 -> loadData=0x0000_BEEF. Then back-to-back LW addr=0x204 -> accepted in the RESP cycle with no bubble.
- SB: addr=0x11, storeData=0xAB, funct3=000 -> ramWe=1, ramBe=0010, ramWdata=0xABAB_ABAB. Result has regWriteEnableOut=0.
- Misaligned LW at addr=0x102 -> ramReq never asserted, misalignErr pulses, regWriteEnableOut=0. Timeout: no ramReady for 255 cycles -> busErr pulse, FSM returns to IDLE.
- Reset mid-access: rst_n=0 in ACCESS -> ramReq, stall and outValid are 0 immediately. After release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage between EX/MEM and MEM/WB. Aligns and extends loads,
// lane-replicates stores, drives a request/ready data-RAM port and holds
// back upstream stages while an access is outstanding.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; accepts a new instruction
// ACCESS | RAM request outstanding; waiting for ramReady or timeout
// RESP   | load/store result on the outputs; accepts a new instruction
module mem_access_unit #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inValid,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [2:0]            funct3,
   input  logic [DATA_W-1:0]     addr,
   input  logic [DATA_W-1:0]     storeData,
   input  logic                  regWriteEnableIn,
   input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
   output logic                  stall,
   output logic                  ramReq,
   output logic                  ramWe,
   output logic [DATA_W-1:0]     ramAddr,
   output logic [DATA_W-1:0]     ramWdata,
   output logic [3:0]            ramBe,
   input  logic                  ramReady,
   input  logic [DATA_W-1:0]     ramRdata,
   output logic                  outValid,
   output logic                  select,
   output logic [DATA_W-1:0]     loadData,
   output logic [DATA_W-1:0]     aluData,
   output logic                  regWriteEnableOut,
   output logic [REG_ADDR_W-1:0] writeBackAddrOut,
   output logic                  misalignErr,
   output logic                  busErr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]      wait_cnt;
   logic                  is_mem;
   logic                  is_store;
   logic                  misaligned;
   logic                  can_accept;
   logic                  acc_alu;
   logic                  acc_mis;
   logic                  acc_mem;
   logic                  timeout_hit;
   logic [3:0]            be_nxt;
   logic [DATA_W-1:0]     wdata_nxt;
   logic [DATA_W-1:0]     ld_shift;
   logic [DATA_W-1:0]     ld_ext;

   logic [DATA_W-1:0]     op_addr;
   logic                  op_store;
   logic [2:0]            op_funct3;
   logic                  op_wen;
   logic [REG_ADDR_W-1:0] op_rd;
   logic [3:0]            op_be;
   logic [DATA_W-1:0]     op_wdata;

   // Decode of the incoming instruction; read+write together counts as a load.
   always_comb begin
      is_mem      = memRead | memWrite;
      is_store    = memWrite & ~memRead;
      misaligned  = ((funct3[1:0] == 2'b01) & addr[0]) |
                    (funct3[1] & (addr[1:0] != 2'b00));
      can_accept  = (state != ACCESS);
      acc_alu     = can_accept & inValid & ~is_mem;
      acc_mis     = can_accept & inValid & is_mem & misaligned;
      acc_mem     = can_accept & inValid & is_mem & ~misaligned;
      timeout_hit = (state == ACCESS) & ~ramReady &
                    (wait_cnt == CNT_W'(TIMEOUT - 1));
   end

   // Byte enables and lane-replicated write data for the access being accepted.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = storeData;
      case (funct3[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {(DATA_W/8){storeData[7:0]}};
         end
         2'b01: begin
            be_nxt    = 4'b0011 << addr[1:0];
            wdata_nxt = {(DATA_W/16){storeData[15:0]}};
         end
         default: begin
            be_nxt    = 4'b1111;
            wdata_nxt = storeData;
         end
      endcase
   end

   // Load alignment: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      ld_shift = ramRdata >> {op_addr[1:0], 3'b000};
      case (op_funct3)
         3'b000:  ld_ext = {{(DATA_W-8){ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_ext = {{(DATA_W-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_shift[7:0]};
         3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; RESP behaves like IDLE so accesses can run back to back.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, RESP: begin
            if (acc_mem) begin
               state_nxt = ACCESS;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACCESS: begin
            if (ramReady) begin
               state_nxt = RESP;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = ACCESS;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; the RAM request follows the state so reset drops it at once.
   always_comb begin
      ramReq = 1'b0;
      ramWe  = 1'b0;
      stall  = 1'b0;
      case (state)
         IDLE: begin
            stall = acc_mem;
         end
         ACCESS: begin
            ramReq = 1'b1;
            ramWe  = op_store;
            stall  = 1'b1;
         end
         default: begin
            ramReq = 1'b0;
            ramWe  = 1'b0;
            stall  = 1'b0;
         end
      endcase
   end

   // RAM port fields come from the captured operation so they hold until ramReady.
   always_comb begin
      ramAddr  = {op_addr[DATA_W-1:2], 2'b00};
      ramWdata = op_wdata;
      ramBe    = op_be;
   end

   // Capture the accepted memory operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_addr   <= '0;
         op_store  <= 1'b0;
         op_funct3 <= 3'b000;
         op_wen    <= 1'b0;
         op_rd     <= '0;
         op_be     <= 4'b0000;
         op_wdata  <= '0;
      end else if (acc_mem) begin
         op_addr   <= addr;
         op_store  <= is_store;
         op_funct3 <= funct3;
         op_wen    <= regWriteEnableIn;
         op_rd     <= writeBackAddrIn;
         op_be     <= be_nxt;
         op_wdata  <= wdata_nxt;
      end
   end

   // Ready-wait counter; cleared whenever no access is waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if ((state == ACCESS) && !ramReady && !timeout_hit) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Result register toward MEM/WB; pulses clear each cycle, data holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid          <= 1'b0;
         select            <= 1'b0;
         loadData          <= '0;
         aluData           <= '0;
         regWriteEnableOut <= 1'b0;
         writeBackAddrOut  <= '0;
         misalignErr       <= 1'b0;
         busErr            <= 1'b0;
      end else begin
         outValid    <= 1'b0;
         misalignErr <= 1'b0;
         busErr      <= 1'b0;
         if (state == ACCESS) begin
            if (ramReady) begin
               outValid          <= 1'b1;
               select            <= ~op_store;
               loadData          <= ld_ext;
               aluData           <= op_addr;
               regWriteEnableOut <= op_wen & ~op_store;
               writeBackAddrOut  <= op_rd;
            end else if (timeout_hit) begin
               outValid          <= 1'b1;
               select            <= 1'b0;
               aluData           <= op_addr;
               regWriteEnableOut <= 1'b0;
               writeBackAddrOut  <= op_rd;
               busErr            <= 1'b1;
            end
         end else if (acc_alu) begin
            outValid          <= 1'b1;
            select            <= 1'b0;
            aluData           <= addr;
            regWriteEnableOut <= regWriteEnableIn;
            writeBackAddrOut  <= writeBackAddrIn;
         end else if (acc_mis) begin
            outValid          <= 1'b1;
            select            <= 1'b0;
            aluData           <= addr;
            regWriteEnableOut <= 1'b0;
            writeBackAddrOut  <= writeBackAddrIn;
            misalignErr       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: every issued instruction pushes its
// expected result (and expected RAM request), checked when the DUT produces it.
module tb_mem_access_unit;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int TO = 255;

   logic          clk;
   logic          rst_n;
   logic          inValid;
   logic          memRead;
   logic          memWrite;
   logic [2:0]    funct3;
   logic [DW-1:0] addr;
   logic [DW-1:0] storeData;
   logic          regWriteEnableIn;
   logic [RW-1:0] writeBackAddrIn;
   logic          stall;
   logic          ramReq;
   logic          ramWe;
   logic [DW-1:0] ramAddr;
   logic [DW-1:0] ramWdata;
   logic [3:0]    ramBe;
   logic          ramReady;
   logic [DW-1:0] ramRdata;
   logic          outValid;
   logic          select;
   logic [DW-1:0] loadData;
   logic [DW-1:0] aluData;
   logic          regWriteEnableOut;
   logic [RW-1:0] writeBackAddrOut;
   logic          misalignErr;
   logic          busErr;

   mem_access_unit #(.DATA_W(DW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .memRead(memRead),
      .memWrite(memWrite), .funct3(funct3), .addr(addr), .storeData(storeData),
      .regWriteEnableIn(regWriteEnableIn), .writeBackAddrIn(writeBackAddrIn),
      .stall(stall), .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr),
      .ramWdata(ramWdata), .ramBe(ramBe), .ramReady(ramReady), .ramRdata(ramRdata),
      .outValid(outValid), .select(select), .loadData(loadData), .aluData(aluData),
      .regWriteEnableOut(regWriteEnableOut), .writeBackAddrOut(writeBackAddrOut),
      .misalignErr(misalignErr), .busErr(busErr)
   );

   typedef struct {
      logic          sel;
      logic [DW-1:0] ldata;
      logic [DW-1:0] alu;
      logic          wen;
      logic [RW-1:0] rd;
      logic          mis;
      logic          bus;
      int            lat;
      int            t0;
   } res_t;

   typedef struct {
      logic [DW-1:0] raddr;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
      logic          we;
      logic [DW-1:0] rdata;
      int            wt;
   } req_t;

   res_t sb[$];
   req_t rq[$];
   req_t cur;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int rsp_cnt = 0;
   int stall_cnt = 0;
   int req_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      #2;
      if (stall) stall_cnt++;
      if (ramReq) req_cnt++;
   end

   // RAM responder: checks the request fields every ACCESS cycle and answers
   // after the number of idle cycles recorded for that request (never if < 0).
   always @(negedge clk) begin
      if (ramReq) begin
         if (rsp_cnt == 0) begin
            chk("rq_size", 64'(rq.size() > 0), 64'd1);
            if (rq.size() > 0) cur = rq.pop_front();
         end
         chk("ramAddr", ramAddr, cur.raddr);
         chk("ramBe", ramBe, cur.be);
         chk("ramWe", ramWe, cur.we);
         if (cur.we) chk("ramWdata", ramWdata, cur.wdata);
         ramReady = (cur.wt >= 0) && (rsp_cnt == cur.wt);
         ramRdata = ramReady ? cur.rdata : 32'h5A5A_5A5A;
         rsp_cnt++;
      end else begin
         ramReady = 1'b0;
         ramRdata = 32'h0;
         rsp_cnt  = 0;
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (outValid) begin
            chk("sb_size", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               res_t e;
               e = sb.pop_front();
               chk("select", select, e.sel);
               chk("aluData", aluData, e.alu);
               chk("wen", regWriteEnableOut, e.wen);
               chk("rd", writeBackAddrOut, e.rd);
               chk("misalignErr", misalignErr, e.mis);
               chk("busErr", busErr, e.bus);
               chk("latency", 64'(cyc - e.t0), 64'(e.lat));
               if (e.sel) chk("loadData", loadData, e.ldata);
            end
         end else begin
            chk("mis_quiet", misalignErr, 1'b0);
            chk("bus_quiet", busErr, 1'b0);
         end
      end
   end

   // Independent reference for one instruction: result and RAM request.
   task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [DW-1:0] a, input logic [DW-1:0] sd,
                        input logic wen, input logic [RW-1:0] rda,
                        input logic [DW-1:0] rdata, input int wt);
      res_t e;
      req_t r;
      int   n;
      int   lane;
      logic store;
      logic mis;
      logic [7:0]  b;
      logic [15:0] h;
      n = 0;
      @(negedge clk);
      while (ramReq && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("issue_wait", 64'(n), 64'd0);
      lane  = int'(a[1:0]);
      store = wr_op && !rd_op;
      mis   = (f3[1:0] == 2'b01 && a[0]) || (f3[1] && a[1:0] != 2'b00);
      e.sel = 1'b0; e.ldata = '0; e.alu = a; e.wen = wen; e.rd = rda;
      e.mis = 1'b0; e.bus = 1'b0; e.lat = 1; e.t0 = cyc;
      if (rd_op || wr_op) begin
         if (mis) begin
            e.wen = 1'b0;
            e.mis = 1'b1;
         end else begin
            r.raddr = {a[DW-1:2], 2'b00};
            r.we    = store;
            r.rdata = rdata;
            r.wt    = wt;
            r.be    = 4'b0000;
            r.wdata = '0;
            for (int i = 0; i < 4; i++) begin
               if (f3[1:0] == 2'b00) begin
                  r.wdata[8*i +: 8] = sd[7:0];
                  if (i == lane) r.be[i] = 1'b1;
               end else if (f3[1:0] == 2'b01) begin
                  r.wdata[8*i +: 8] = sd[8*(i%2) +: 8];
                  if (i == lane || i == lane + 1) r.be[i] = 1'b1;
               end else begin
                  r.wdata[8*i +: 8] = sd[8*i +: 8];
                  r.be[i] = 1'b1;
               end
            end
            rq.push_back(r);
            b = rdata[8*lane +: 8];
            h = (lane < 3) ? rdata[8*lane +: 16] : {8'h00, rdata[31:24]};
            case (f3)
               3'b000:  e.ldata = {{24{b[7]}}, b};
               3'b001:  e.ldata = {{16{h[15]}}, h};
               3'b100:  e.ldata = {24'h0, b};
               3'b101:  e.ldata = {16'h0, h};
               default: e.ldata = rdata;
            endcase
            if (wt < 0) begin
               e.wen = 1'b0;
               e.bus = 1'b1;
               e.lat = TO + 1;
            end else begin
               e.sel = !store;
               e.wen = store ? 1'b0 : wen;
               e.lat = wt + 2;
            end
         end
      end
      sb.push_back(e);
      inValid = 1'b1; memRead = rd_op; memWrite = wr_op; funct3 = f3; addr = a;
      storeData = sd; regWriteEnableIn = wen; writeBackAddrIn = rda;
      @(posedge clk);
      #1 inValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      funct3 = 3'b000; addr = '0; storeData = '0; regWriteEnableIn = 1'b0;
      writeBackAddrIn = '0; ramReady = 1'b0; ramRdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_outValid", outValid, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_ramReq", ramReq, 1'b0);
      chk("rst_ramAddr", ramAddr, 32'h0);
      chk("rst_ramBe", ramBe, 4'h0);
      chk("rst_aluData", aluData, 32'h0);
      chk("rst_loadData", loadData, 32'h0);
      chk("rst_errs", {misalignErr, busErr, select, regWriteEnableOut}, 4'h0);
      rst_n = 1'b1;

      // ALU pass-through never stalls
      stall_cnt = 0;
      issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 5'd5, 32'h0, 0);
      issue(1'b0, 1'b0, 3'b010, 32'hFFFF_0001, 32'h0, 1'b0, 5'd31, 32'h0, 0);
      drain();
      chk("alu_stall_cycles", 64'(stall_cnt), 64'd0);

      // LB sign-extended, ready on third ACCESS cycle
      stall_cnt = 0;
      issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7, 32'h80FF_0000, 2);
      drain();
      chk("lb_stall_cycles", 64'(stall_cnt), 64'd4);

      // LHU then back-to-back LW presented in the RESP cycle
      issue(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1'b1, 5'd8, 32'hBEEF_1234, 0);
      issue(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 1'b1, 5'd9, 32'hCAFE_F00D, 1);
      issue(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 1'b1, 5'd3, 32'h8001_7FFF, 0);
      issue(1'b1, 1'b0, 3'b100, 32'h301, 32'h0, 1'b1, 5'd4, 32'h0000_9A00, 0);
      drain();

      // Stores
      issue(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b1, 5'd10, 32'h0, 0);
      issue(1'b0, 1'b1, 3'b001, 32'h16, 32'h1234_5678, 1'b1, 5'd11, 32'h0, 1);
      issue(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b1, 5'd12, 32'h0, 0);
      drain();

      // read+write together behaves as a load
      issue(1'b1, 1'b1, 3'b010, 32'h40, 32'hFFFF_FFFF, 1'b1, 5'd13, 32'h1122_3344, 0);
      drain();

      // Misaligned accesses never reach the RAM
      req_cnt = 0;
      issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 5'd14, 32'h0, 0);
      issue(1'b0, 1'b1, 3'b001, 32'h33, 32'h0, 1'b1, 5'd15, 32'h0, 0);
      drain();
      chk("mis_no_req", 64'(req_cnt), 64'd0);

      // Timeout, then the unit is idle again
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd16, 32'h0, -1);
      drain();
      chk("to_req_dropped", ramReq, 1'b0);
      issue(1'b0, 1'b0, 3'b000, 32'h5555, 32'h0, 1'b1, 5'd17, 32'h0, 0);
      drain();

      // Reset in the middle of an access
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 5'd18, 32'h0, -1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_ramReq", ramReq, 1'b0);
      chk("rstmid_stall", stall, 1'b0);
      chk("rstmid_outValid", outValid, 1'b0);
      sb.delete();
      rq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 1'b1, 5'd19, 32'h7654_3210, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
